// File: rtl/pomdp_episode_stats.sv
// Episode statistics accumulator for the POMDP simulator step stream.
// Gathers total reward (saturating), step count, per-action counts and
// observation/state matches, then offers the record over valid/ready.
module pomdp_episode_stats #(
  parameter int unsigned REWARD_W    = 16,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_ACTIONS = 3,
  parameter int unsigned EPISODE_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         step_valid,
  input  logic [REWARD_W-1:0]          step_reward,
  input  logic [1:0]                   step_action,
  input  logic                         step_obs,
  input  logic                         step_state,
  output logic                         busy,
  output logic                         ep_valid,
  input  logic                         ep_ready,
  output logic [ACC_W-1:0]             ep_total,
  output logic [CNT_W-1:0]             ep_steps,
  output logic [NUM_ACTIONS*CNT_W-1:0] ep_act_cnt,
  output logic [CNT_W-1:0]             ep_match,
  output logic                         ep_sat,
  output logic                         ep_bad_act
);

  localparam int unsigned SUM_W = ((ACC_W > REWARD_W) ? ACC_W : REWARD_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(EPISODE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic   clr;
  logic   acc_en;

  logic [SUM_W-1:0] sum;
  logic             sum_ovf;
  logic             act_bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode, accumulator clear/enable strobes
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    acc_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
          clr      = 1'b1;
        end
      end
      S_RUN: begin
        if (start) begin
          clr = 1'b1;
        end else if (step_valid) begin
          acc_en = 1'b1;
          if (ep_steps == LAST_STEP) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (ep_ready) begin
          if (start) begin
            state_nx = S_RUN;
            clr      = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy     = (state == S_RUN);
  assign ep_valid = (state == S_DONE);

  // Reward sum computed one bit wider so an overflow shows up as a carry
  always_comb begin
    sum     = SUM_W'(ep_total) + SUM_W'(step_reward);
    sum_ovf = |sum[SUM_W-1:ACC_W];
    act_bad = ({30'd0, step_action} >= NUM_ACTIONS);
  end

  // Episode accumulators; held while idle or awaiting acceptance
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ep_total   <= '0;
      ep_steps   <= '0;
      ep_act_cnt <= '0;
      ep_match   <= '0;
      ep_sat     <= 1'b0;
      ep_bad_act <= 1'b0;
    end else if (acc_en) begin
      if (sum_ovf) begin
        ep_total <= '1;
        ep_sat   <= 1'b1;
      end else begin
        ep_total <= sum[ACC_W-1:0];
      end
      ep_steps <= ep_steps + CNT_W'(1);
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
        if (step_action == 2'(a))
          ep_act_cnt[a*CNT_W +: CNT_W] <= ep_act_cnt[a*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (act_bad) ep_bad_act <= 1'b1;
      if (step_obs == step_state) ep_match <= ep_match + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pomdp_episode_stats.sv
// Randomized scoreboard bench for pomdp_episode_stats.
module tb_pomdp_episode_stats;

  localparam int unsigned REWARD_W = 16;
  localparam int unsigned ACC_W    = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NA       = 3;
  localparam int unsigned EL       = 64;
  localparam longint      MAXT     = (64'd1 << ACC_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic                  rst, start, step_valid, step_obs, step_state, ep_ready;
  logic [REWARD_W-1:0]   step_reward;
  logic [1:0]            step_action;
  logic                  busy, ep_valid, ep_sat, ep_bad_act;
  logic [ACC_W-1:0]      ep_total;
  logic [CNT_W-1:0]      ep_steps, ep_match;
  logic [NA*CNT_W-1:0]   ep_act_cnt;

  pomdp_episode_stats #(
    .REWARD_W(REWARD_W), .ACC_W(ACC_W), .CNT_W(CNT_W),
    .NUM_ACTIONS(NA), .EPISODE_LEN(EL)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .step_valid(step_valid),
    .step_reward(step_reward), .step_action(step_action),
    .step_obs(step_obs), .step_state(step_state),
    .busy(busy), .ep_valid(ep_valid), .ep_ready(ep_ready),
    .ep_total(ep_total), .ep_steps(ep_steps), .ep_act_cnt(ep_act_cnt),
    .ep_match(ep_match), .ep_sat(ep_sat), .ep_bad_act(ep_bad_act)
  );

  // narrow-accumulator instance for saturation
  logic              s_start, s_valid, s_ready;
  logic [15:0]       s_reward;
  logic              s_busy, s_ep_valid, s_sat, s_bad;
  logic [15:0]       s_total, s_steps, s_match;
  logic [3*16-1:0]   s_act;

  pomdp_episode_stats #(
    .REWARD_W(16), .ACC_W(16), .CNT_W(16), .NUM_ACTIONS(3), .EPISODE_LEN(10)
  ) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .step_valid(s_valid),
    .step_reward(s_reward), .step_action(2'd0),
    .step_obs(1'b1), .step_state(1'b1),
    .busy(s_busy), .ep_valid(s_ep_valid), .ep_ready(s_ready),
    .ep_total(s_total), .ep_steps(s_steps), .ep_act_cnt(s_act),
    .ep_match(s_match), .ep_sat(s_sat), .ep_bad_act(s_bad)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    longint total;
    int     steps;
    int     act[NA];
    int     match;
    bit     sat;
    bit     bad;
  } rec_t;

  rec_t exp_q[$];

  // reference model: episode contents and phase, from the step-record rules
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
  phase_t m_phase;
  longint m_total;
  int     m_steps, m_match;
  int     m_act[NA];
  bit     m_sat, m_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_total = 0; m_steps = 0; m_match = 0; m_sat = 0; m_bad = 0;
    for (int a = 0; a < NA; a++) m_act[a] = 0;
  endfunction

  function automatic void model_step(input int r, input int a, input bit o, input bit s);
    rec_t rec;
    m_total = m_total + r;
    if (m_total > MAXT) begin m_total = MAXT; m_sat = 1; end
    m_steps++;
    if (a < NA) m_act[a]++; else m_bad = 1;
    if (o == s) m_match++;
    if (m_steps == EL) begin
      rec.total = m_total; rec.steps = m_steps; rec.match = m_match;
      rec.sat = m_sat; rec.bad = m_bad;
      for (int k = 0; k < NA; k++) rec.act[k] = m_act[k];
      exp_q.push_back(rec);
      m_phase = P_DONE;
    end
  endfunction

  // Drive one cycle of inputs (called at a negedge), update the model, wait to next negedge
  task automatic cycle(input bit st, input bit v, input int r, input int a,
                       input bit o, input bit s, input bit rdy);
    start = st; step_valid = v; step_reward = REWARD_W'(r);
    step_action = 2'(a); step_obs = o; step_state = s; ep_ready = rdy;
    case (m_phase)
      P_IDLE: if (st) begin model_clear(); m_phase = P_RUN; end
      P_RUN:  if (st) model_clear(); else if (v) model_step(r, a, o, s);
      P_DONE: if (rdy) begin
                if (st) begin model_clear(); m_phase = P_RUN; end
                else m_phase = P_IDLE;
              end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_total"}, longint'(ep_total), m_total);
    chk({tag, "_steps"}, longint'(ep_steps), m_steps);
    chk({tag, "_match"}, longint'(ep_match), m_match);
    chk({tag, "_sat"},   longint'(ep_sat), m_sat);
    chk({tag, "_bad"},   longint'(ep_bad_act), m_bad);
    for (int a = 0; a < NA; a++)
      chk({tag, "_act"}, longint'(ep_act_cnt[a*CNT_W +: CNT_W]), m_act[a]);
    chk({tag, "_busy"},  longint'(busy), (m_phase == P_RUN) ? 1 : 0);
    chk({tag, "_valid"}, longint'(ep_valid), (m_phase == P_DONE) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    m_phase = P_IDLE;
    model_clear();
  endtask

  // Monitor: compare each newly presented record against the scoreboard
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (ep_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_total", longint'(ep_total), e.total);
        chk("rec_steps", longint'(ep_steps), e.steps);
        chk("rec_match", longint'(ep_match), e.match);
        chk("rec_sat",   longint'(ep_sat), e.sat);
        chk("rec_bad",   longint'(ep_bad_act), e.bad);
        for (int a = 0; a < NA; a++)
          chk("rec_act", longint'(ep_act_cnt[a*CNT_W +: CNT_W]), e.act[a]);
      end
    end
    prev_valid = ep_valid;
  end

  task automatic rand_step(input bit allow_restart);
    bit st;
    st = allow_restart && ($urandom_range(0, 99) == 0);
    cycle(st, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    rst = 0; start = 0; step_valid = 0; step_reward = '0; step_action = '0;
    step_obs = 0; step_state = 0; ep_ready = 0;
    s_start = 0; s_valid = 0; s_ready = 0; s_reward = '0;
    m_phase = P_IDLE;
    model_clear();
    @(negedge clk);
    do_reset();
    chk_regs("reset");

    // reset mid-run after 10 steps
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 100 + i, i % 3, 1, 1, 0);
    chk("pre_reset_steps", longint'(ep_steps), 10);
    do_reset();
    chk_regs("midrun_reset");

    // 64 identical steps
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < EL; i++) cycle(0, 1, 7209, 0, i[0], i[0], 0);
    chk("valid_after_last", longint'(ep_valid), 1);
    chk("total_461376", longint'(ep_total), 461376);
    chk_regs("full_ep");

    // hold ready low with start/step_valid toggling
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)), 1, 0, 1, 0);
      chk_regs("hold");
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_regs("accepted");
    chk("idle_after_accept", longint'(ep_valid), 0);

    // mixed actions incl. illegal code, mismatches on odd steps
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < EL; i++) cycle(0, 1, i * 3, i % 4, 1'b0, i[0], 0);
    chk_regs("mixed");
    chk("mixed_match32", longint'(ep_match), 32);

    // accept and restart on the same cycle, then restart mid-run
    cycle(1, 0, 0, 0, 0, 0, 1);
    chk_regs("done_restart");
    for (int i = 0; i < 5; i++) cycle(0, 1, 9, 2, 0, 0, 0);
    chk("five_steps", longint'(ep_steps), 5);
    cycle(1, 1, 9, 2, 0, 0, 0);
    chk_regs("run_restart");

    // randomized episodes with random acceptance delay
    for (int ep = 0; ep < 8; ep++) begin
      int guard;
      guard = 0;
      if (m_phase != P_RUN) cycle(1, 0, 0, 0, 0, 0, 0);
      while (m_phase != P_DONE && guard < 2000) begin
        rand_step(ep[0]);
        guard++;
      end
      chk("episode_reached_done", (m_phase == P_DONE) ? 1 : 0, 1);
      repeat ($urandom_range(0, 3)) rand_step(1'b0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk_regs("rand_accept");
    end

    // narrow accumulator saturation: 10 x 16'hffff
    s_start = 1;
    @(negedge clk);
    s_start = 0; s_valid = 1; s_reward = 16'hffff;
    repeat (10) @(negedge clk);
    s_valid = 0;
    chk("sat_valid", longint'(s_ep_valid), 1);
    chk("sat_total", longint'(s_total), 16'hffff);
    chk("sat_flag",  longint'(s_sat), 1);
    chk("sat_steps", longint'(s_steps), 10);
    chk("sat_act0",  longint'(s_act[15:0]), 10);
    chk("sat_match", longint'(s_match), 10);
    s_ready = 1;
    @(negedge clk);
    s_ready = 0;
    chk("sat_accept", longint'(s_ep_valid), 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
